// File: rtl/tl45_decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : tl45_decode_queue_if
// Purpose  : Fetch-side, execute-side and error-capture signals of the
//            TL45 decode queue, bundled with master/slave views.
// Revision : 1.0
// ============================================================================
interface tl45_decode_queue_if;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc;
    logic [31:0] i_inst;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [4:0]  o_opcode;
    logic        o_ri;
    logic [3:0]  o_dr;
    logic [3:0]  o_sr1;
    logic [3:0]  o_sr2;
    logic [31:0] o_imm;
    logic        o_err;
    logic [31:0] o_err_pc;
    logic        i_err_clr;

    modport slave (
        input  i_flush, i_valid, i_pc, i_inst, i_ready, i_err_clr,
        output o_ready, o_valid, o_pc, o_opcode, o_ri, o_dr, o_sr1, o_sr2,
               o_imm, o_err, o_err_pc
    );

    modport master (
        output i_flush, i_valid, i_pc, i_inst, i_ready, i_err_clr,
        input  o_ready, o_valid, o_pc, o_opcode, o_ri, o_dr, o_sr1, o_sr2,
               o_imm, o_err, o_err_pc
    );
endinterface
`default_nettype wire

// File: rtl/tl45_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tl45_decode_queue
// Purpose  : TL45 decode with valid/ready handshake, DEPTH-entry decoded
//            instruction queue and illegal-instruction PC capture.
// Revision : 1.0
// ============================================================================
module tl45_decode_queue #(
    parameter int         DEPTH      = 2,
    parameter logic [3:0] SP_REG     = 4'hF,
    parameter bit         ERR_STICKY = 1'b1
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset_n,
    tl45_decode_queue_if.slave  dq
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  opcode;
        logic        ri;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm;
    } entry_t;

    logic [4:0]  w_opcode;
    logic        w_ri, w_lh, w_zs;
    logic [2:0]  w_mode;
    logic [3:0]  w_dr, w_sr1, w_sr2_fld;
    logic [15:0] w_imm16;
    logic [11:0] w_low_imm;
    logic [31:0] w_imm;
    logic        w_legal;
    logic [3:0]  w_dr_q, w_sr2_q;
    entry_t      w_entry;

    assign w_opcode  = dq.i_inst[31:27];
    assign w_ri      = dq.i_inst[26];
    assign w_lh      = dq.i_inst[25];
    assign w_zs      = dq.i_inst[24];
    assign w_dr      = dq.i_inst[23:20];
    assign w_sr1     = dq.i_inst[19:16];
    assign w_imm16   = dq.i_inst[15:0];
    assign w_sr2_fld = dq.i_inst[15:12];
    assign w_low_imm = dq.i_inst[11:0];
    assign w_mode    = {w_ri, w_lh, w_zs};

    always_comb begin
        if (w_lh)
            w_imm = {w_imm16, 16'h0000};
        else if (w_zs)
            w_imm = {{16{w_imm16[15]}}, w_imm16};
        else
            w_imm = {16'h0000, w_imm16};
    end

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            5'h00:                      w_legal = (dq.i_inst == 32'h0);
            5'h01, 5'h02, 5'h06,
            5'h07, 5'h08:               w_legal = w_ri || (w_mode == 3'b000 && w_low_imm == 12'h0);
            5'h09:                      w_legal = (w_mode == 3'b000) && (w_low_imm == 12'h0);
            5'h0C, 5'h0D:               w_legal = (w_mode == 3'b101);
            5'h0E:                      w_legal = (w_mode == 3'b000) && (w_dr == SP_REG) &&
                                                  (w_sr1 == 4'h0) && (w_imm16 == 16'h0);
            5'h10:                      w_legal = (w_mode == 3'b000) && (w_sr1 == 4'h0);
            5'h11:                      w_legal = (w_mode == 3'b000) && (w_dr == 4'h0);
            5'h14, 5'h15:               w_legal = (w_mode == 3'b001);
            default:                    w_legal = 1'b0;
        endcase
    end

    // SW stores dr as its data source, so it moves to sr2 and dr is zeroed.
    always_comb begin
        w_dr_q = (w_opcode == 5'h15) ? 4'h0 : w_dr;
        if (w_opcode == 5'h0D || w_opcode == 5'h0E)
            w_sr2_q = SP_REG;
        else if (w_opcode == 5'h15)
            w_sr2_q = w_dr;
        else if (w_ri)
            w_sr2_q = 4'h0;
        else
            w_sr2_q = w_sr2_fld;
    end

    assign w_entry = '{pc: dq.i_pc, opcode: w_opcode, ri: w_ri, dr: w_dr_q,
                       sr1: w_sr1, sr2: w_sr2_q, imm: w_imm};

    entry_t             r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [c_CNT_W-1:0] r_count, w_count_nxt;
    logic               r_ready;
    logic               r_err;
    logic [31:0]        r_err_pc;
    logic               w_valid, w_accept, w_push, w_pop, w_ill;

    assign w_valid  = (r_count != '0);
    assign w_accept = dq.i_valid && r_ready && !dq.i_flush;
    assign w_push   = w_accept && w_legal;
    assign w_ill    = w_accept && !w_legal;
    assign w_pop    = w_valid && dq.i_ready && !dq.i_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (dq.i_flush)
            w_count_nxt = '0;
        else if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (w_pop && !w_push)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    // Ready is precomputed from the next count so it never depends on i_ready.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < c_DEPTH);
            if (dq.i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_err    <= 1'b0;
            r_err_pc <= 32'h0;
        end else if (w_ill) begin
            r_err <= 1'b1;
            if (!r_err || dq.i_err_clr)
                r_err_pc <= dq.i_pc;
        end else begin
            if (dq.i_err_clr || !ERR_STICKY)
                r_err <= 1'b0;
            if (dq.i_err_clr)
                r_err_pc <= 32'h0;
        end
    end

    entry_t w_head;
    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign dq.o_ready  = r_ready;
    assign dq.o_valid  = w_valid;
    assign dq.o_pc     = w_head.pc;
    assign dq.o_opcode = w_head.opcode;
    assign dq.o_ri     = w_head.ri;
    assign dq.o_dr     = w_head.dr;
    assign dq.o_sr1    = w_head.sr1;
    assign dq.o_sr2    = w_head.sr2;
    assign dq.o_imm    = w_head.imm;
    assign dq.o_err    = r_err;
    assign dq.o_err_pc = r_err_pc;

endmodule
`default_nettype wire

// File: tb/tb_tl45_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl45_decode_queue
// Purpose  : Self-checking bench for tl45_decode_queue (DEPTH=4, sticky error).
// Revision : 1.0
// ============================================================================
module tb_tl45_decode_queue;
    localparam int         c_DEPTH = 4;
    localparam logic [3:0] c_SP    = 4'hF;
    localparam int         c_NV    = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  op;
        logic        ri;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm;
    } entry_t;

    typedef struct {
        logic [31:0] inst;
        logic        legal;
        logic [3:0]  dr;
        logic [3:0]  sr2;
        logic [31:0] imm;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    tl45_decode_queue_if dq ();

    tl45_decode_queue #(
        .DEPTH      (c_DEPTH),
        .SP_REG     (c_SP),
        .ERR_STICKY (1'b1)
    ) u_dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .dq        (dq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: queue contents, ready flag, error capture.
    entry_t      mq[$];
    logic        m_ready;
    logic        m_err;
    logic [31:0] m_err_pc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] x, input logic [31:0] pc,
                                       output logic legal, output entry_t e);
        logic [4:0]  op;
        logic [2:0]  mode;
        logic [3:0]  dr, sr1, sr2f;
        logic [15:0] imm16;
        logic [11:0] low;
        op = x[31:27]; mode = x[26:24]; dr = x[23:20]; sr1 = x[19:16];
        imm16 = x[15:0]; sr2f = x[15:12]; low = x[11:0];
        case (op)
            5'd0:                         legal = (x == 32'd0);
            5'd1, 5'd2, 5'd6, 5'd7, 5'd8: legal = mode[2] || (mode == 3'd0 && low == 12'd0);
            5'd9:                         legal = (mode == 3'd0 && low == 12'd0);
            5'd12, 5'd13:                 legal = (mode == 3'd5);
            5'd14:                        legal = (mode == 3'd0 && dr == c_SP && sr1 == 4'd0 && imm16 == 16'd0);
            5'd16:                        legal = (mode == 3'd0 && sr1 == 4'd0);
            5'd17:                        legal = (mode == 3'd0 && dr == 4'd0);
            5'd20, 5'd21:                 legal = (mode == 3'd1);
            default:                      legal = 1'b0;
        endcase
        e.pc  = pc;
        e.op  = op;
        e.ri  = mode[2];
        e.sr1 = sr1;
        e.dr  = (op == 5'd21) ? 4'd0 : dr;
        if (op == 5'd13 || op == 5'd14) e.sr2 = c_SP;
        else if (op == 5'd21)           e.sr2 = dr;
        else if (mode[2])               e.sr2 = 4'd0;
        else                            e.sr2 = sr2f;
        if (mode[1])                         e.imm = {16'd0, imm16} * 32'd65536;
        else if (mode[0] && imm16 >= 16'h8000) e.imm = {16'd0, imm16} - 32'd65536;
        else                                 e.imm = {16'd0, imm16};
    endfunction

    task automatic check_all();
        entry_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("o_valid", 128'(dq.o_valid), 128'(mq.size() != 0));
        chk("o_ready", 128'(dq.o_ready), 128'(m_ready));
        chk("head", 128'({dq.o_pc, dq.o_opcode, dq.o_ri, dq.o_dr, dq.o_sr1, dq.o_sr2, dq.o_imm}), 128'(h));
        chk("o_err", 128'(dq.o_err), 128'(m_err));
        chk("o_err_pc", 128'(dq.o_err_pc), 128'(m_err_pc));
    endtask

    // One clock: drive inputs, advance model, check all outputs #1 after the edge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic clr);
        logic   legal, acc, pop;
        entry_t e;
        dq.i_valid = v; dq.i_inst = inst; dq.i_pc = pc;
        dq.i_ready = rdy; dq.i_flush = fl; dq.i_err_clr = clr;
        ref_decode(inst, pc, legal, e);
        acc = v && m_ready && !fl;
        pop = (mq.size() != 0) && rdy && !fl;
        @(posedge clk);
        #1;
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc && legal) mq.push_back(e);
        end
        if (acc && !legal) begin
            if (!m_err || clr) m_err_pc = pc;
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
            m_err_pc = 32'd0;
        end
        m_ready = (mq.size() < c_DEPTH);
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready  = 1'b0;
        m_err    = 1'b0;
        m_err_pc = 32'd0;
    endtask

    vec_t vec [c_NV];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vec[0]  = '{32'h0C12FFFF, 1'b1, 4'd1, 4'd0, 32'h0000FFFF};  // ADD imm
        vec[1]  = '{32'hA9348000, 1'b1, 4'd0, 4'd3, 32'hFFFF8000};  // SW
        vec[2]  = '{32'h0E561234, 1'b1, 4'd5, 4'd0, 32'h12340000};  // LH imm
        vec[3]  = '{32'h6D230010, 1'b1, 4'd2, 4'hF, 32'h00000010};  // CALL
        vec[4]  = '{32'h70F00000, 1'b1, 4'hF, 4'hF, 32'h00000000};  // RET
        vec[5]  = '{32'h10123000, 1'b1, 4'd1, 4'd3, 32'h00003000};  // op02 reg
        vec[6]  = '{32'h10123001, 1'b0, 4'd0, 4'd0, 32'h0};
        vec[7]  = '{32'h00000000, 1'b1, 4'd0, 4'd0, 32'h0};         // NOP
        vec[8]  = '{32'h00000001, 1'b0, 4'd0, 4'd0, 32'h0};
        vec[9]  = '{32'hF8000000, 1'b0, 4'd0, 4'd0, 32'h0};
        vec[10] = '{32'h18000000, 1'b0, 4'd0, 4'd0, 32'h0};
        vec[11] = '{32'h80709000, 1'b1, 4'd7, 4'd9, 32'h00009000};  // op10
        vec[12] = '{32'hA11200FF, 1'b1, 4'd1, 4'd0, 32'h000000FF};  // op14
        vec[13] = '{32'h64000000, 1'b0, 4'd0, 4'd0, 32'h0};         // 0C bad mode
        vec[14] = '{32'h88056000, 1'b1, 4'd0, 4'd6, 32'h00006000};  // op11
        vec[15] = '{32'h48200000, 1'b1, 4'd2, 4'd0, 32'h0};         // op09

        dq.i_valid = 1'b0; dq.i_inst = '0; dq.i_pc = '0;
        dq.i_ready = 1'b0; dq.i_flush = 1'b0; dq.i_err_clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Table: each vector lands at head with the previous one popped.
        for (int i = 0; i < c_NV; i++) begin
            logic [31:0] pc;
            pc = 32'h1000 + 32'(i * 4);
            cycle(1'b1, vec[i].inst, pc, 1'b1, 1'b0, 1'b1);
            if (vec[i].legal) begin
                chk("tbl_valid", 128'(dq.o_valid), 128'(1'b1));
                chk("tbl_fields", 128'({dq.o_pc, dq.o_dr, dq.o_sr2, dq.o_imm}),
                    128'({pc, vec[i].dr, vec[i].sr2, vec[i].imm}));
                chk("tbl_err", 128'(dq.o_err), 128'(1'b0));
            end else begin
                chk("tbl_valid", 128'(dq.o_valid), 128'(1'b0));
                chk("tbl_err", 128'({dq.o_err, dq.o_err_pc}), 128'({1'b1, pc}));
            end
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Full queue: 6 offers, 4 accepted; one pop reopens ready.
        for (int k = 0; k < 6; k++)
            cycle(1'b1, 32'h0C12FFFF, 32'h300 + 32'(k * 4), 1'b0, 1'b0, 1'b0);
        chk("full_ready", 128'(dq.o_ready), 128'(1'b0));
        chk("full_head", 128'(dq.o_pc), 128'(32'h300));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pop_ready", 128'(dq.o_ready), 128'(1'b1));
        chk("pop_head", 128'(dq.o_pc), 128'(32'h304));
        for (int k = 0; k < 12; k++)
            cycle(1'b1, 32'h0C12FFFF, 32'h400 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Illegal capture is sticky to the first PC until cleared.
        cycle(1'b1, 32'hF8000000, 32'h200, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h18000000, 32'h204, 1'b1, 1'b0, 1'b0);
        chk("ill_state", 128'({dq.o_valid, dq.o_err, dq.o_err_pc}), 128'({1'b0, 1'b1, 32'h200}));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("ill_clr", 128'(dq.o_err), 128'(1'b0));

        // Flush with 3 queued and an illegal input offered.
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 32'h0C12FFFF, 32'h600 + 32'(k * 4), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hF8000000, 32'h666, 1'b0, 1'b1, 1'b0);
        chk("flush", 128'({dq.o_valid, dq.o_err, dq.o_ready}), 128'({1'b0, 1'b0, 1'b1}));
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Async reset mid-stream with entries queued and an error captured.
        cycle(1'b1, 32'hF8000000, 32'h700, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h6D230010, 32'h500, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h70F00000, 32'h504, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] inst;
            inst = vec[$urandom_range(c_NV - 1)].inst;
            if ($urandom_range(3) == 0) inst = inst ^ 32'($urandom_range(16'hFFFF));
            if ($urandom_range(7) == 0) inst = $urandom;
            cycle($urandom_range(9) < 7, inst, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(9) < 5, $urandom_range(24) == 0, $urandom_range(11) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tl45_decode_queue.md
# tl45_decode_queue

Parametrised successor to the TL45 decode stage. It replaces the global stall input with a valid/ready handshake on both sides and adds a DEPTH-entry decoded-instruction queue between fetch and execute. It also adds sticky illegal-instruction capture with the faulting PC. Field extraction, immediate resolution, SW operand reordering and CALL/RET stack-pointer forcing are performed before enqueue, so execute sees canonical operands.

## Interface
- DEPTH, 2: queue entries; power of two, 2..8
- SP_REG, 4'hF: register index forced into sr2 for CALL/RET and required as RET dr
- ERR_STICKY, 1: 1 = error flag holds until i_err_clr; 0 = one-cycle pulse only
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush, drops queue and input this cycle
- i_valid  in  1  fetch offers i_pc/i_inst
- o_ready  out  1  decode accepts this cycle
- i_pc  in  32  instruction PC
- i_inst  in  32  raw instruction
- o_valid  out  1  queue head valid
- i_ready  in  1  execute consumes head this cycle
- o_pc  out  32  head PC
- o_opcode  out  5  head opcode
- o_ri  out  1  head register/immediate flag
- o_dr, o_sr1, o_sr2  out  4 each  head register indices
- o_imm  out  32  head resolved immediate
- o_err  out  1  illegal instruction seen
- o_err_pc  out  32  PC of first illegal instruction since last clear
- i_err_clr  in  1  clears o_err/o_err_pc capture

## Operation
- Field split: opcode=[31:27], ri=[26], lh=[25], zs=[24], dr=[23:20], sr1=[19:16], imm=[15:0], sr2=[15:12], low_imm=[11:0], mode={ri,lh,zs}.
- imm resolution: lh=1 gives {imm,16'h0}; lh=0,zs=1 gives sign-extend; lh=0,zs=0 gives zero-extend.
- Legality:
  - 00 NOP needs inst==0.
  - 01/02/06/07/08 are illegal if !ri && (mode!=0 || low_imm!=0).
  - 09 needs mode==0, low_imm==0.
  - 0C/0D need mode==3'b101.
  - 0E needs mode==0, dr==SP_REG, sr1==0, imm==0.
  - 10 needs mode==0, sr1==0.
  - 11 needs mode==0, dr==0.
  - 14/15 need mode==3'b001.
  - All other opcodes are illegal.
- Enqueued operands:
  - dr is 0 for SW (15), else dr.
  - sr2 selection, first match wins: SP_REG for 0D/0E; then dr for 15; then 0 if ri; else sr2.
  - imm is always the resolved value.
- Handshake and enqueue:
  - Accept when i_valid && o_ready && !i_flush.
  - A legal accept pushes an entry. An illegal accept is consumed but not pushed.
- Dequeue when o_valid && i_ready.
- Queue is a circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Error capture:
  - An illegal accept sets the error flag.
  - If the flag was clear, that accept also loads o_err_pc.
  - ERR_STICKY=0: flag lasts one cycle.
  - i_err_clr clears the flag. If an illegal accept occurs in the same cycle, it sets the flag again and loads o_err_pc with the new PC.

## Timing
- Reset (async assert, sync-released use): every output 0, count 0, pointers 0, o_ready=0 while reset asserted.
- o_ready = (count < DEPTH). Registered from count; no combinational path from i_ready.
- Latency: a legal instruction accepted at edge N is at head with o_valid=1 after edge N when the queue was empty; o_valid=1 from cycle N+1.
- Head outputs come straight from storage at rd pointer. They hold stable while o_valid && !i_ready.
- Outputs are 0 when o_valid=0.
- Push and pop in the same cycle leave count unchanged. This is legal at any count < DEPTH.
- Full (count==DEPTH): o_ready=0 and only a pop is possible.
- Empty: i_ready is ignored.
- i_flush: count, pointers and o_valid are 0 after the edge. The input that cycle is dropped and no error is raised. The error flag and o_err_pc are untouched.
- Reset mid-operation: queue contents are discarded immediately and error capture is cleared.
- o_err is asserted the cycle after the illegal accept.

## Test plan
- **Basic pass-through:** reset, then accept ADD imm inst 0x0C12_FFFF (ri=1, zs=0... opcode 01) at pc 0x100 with i_ready=1. Required: o_valid next cycle, sr2=0, imm=0x0000_FFFF.
- **Immediate and SW forms:** SW with mode 001, dr=3, sr1=4, imm=0x8000. Required: o_dr=0, o_sr2=3, o_imm=0xFFFF_8000. LH form (lh=1), imm=0x1234. Required: o_imm=0x1234_0000.
- **Full queue:** DEPTH=4, i_ready=0, offer 6 legal instructions. Required: o_ready=0 after 4 accepts. Then i_ready=1 for one cycle: pop and o_ready=1 next cycle. Check FIFO order by pc, including pointer wrap after 10 pushes/pops.
- **Illegal instruction:** opcode 1F at pc 0x200, then opcode 03 at pc 0x204. Required: nothing enqueued, o_err=1, o_err_pc=0x200 (sticky). i_err_clr then gives o_err=0.
- **Flush:** flush with 3 queued entries and i_valid=1. Required: o_valid=0 next cycle and count 0. The flushed input is never output, even if illegal.
- **CALL/RET and async reset:** CALL (0D, mode 101) gives sr2=SP_REG. RET with dr=SP_REG, all else 0, is legal. Assert i_reset_n low mid-stream. Required: outputs 0 without a clock edge.
